sdram_multi_arbiter: RTL and testbench

Parametrised N-client arbiter multiplexing one SDRAM controller port (Avalon-style read/write/ack) among the display, audio, background and init engines. It replaces fixed per-phase client selection with urgent-first, round-robin arbitration, per-client enable masking, lock-hold bursts and a starvation cap. It sits between the client engines and the SDRAM controller.

---
 rtl/sdram_multi_arbiter_pkg.sv | 13 +
 rtl/sdram_multi_arbiter_if.sv | 20 ++
 rtl/sdram_multi_arbiter_picker.sv | 33 +++
 rtl/sdram_multi_arbiter.sv | 109 ++++++++++
 tb/tb_sdram_multi_arbiter.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_multi_arbiter_pkg.sv
// Shared types and defaults for the multi-client SDRAM port arbiter.
package sdram_arb_pkg;
  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} arb_state_e;

  localparam int DEF_ADDR_W    = 22;
  localparam int DEF_DATA_W    = 128;
  localparam int DEF_MAX_BURST = 16;

  // Index width that never collapses to zero bits.
  function automatic int clog2w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/sdram_multi_arbiter_if.sv
// Avalon-style SDRAM controller port: arbiter is master, controller is slave.
interface sdram_multi_arbiter_if
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  localparam int BE_W = DATA_W / 8;

  logic [ADDR_W-1:0] addr;
  logic [BE_W-1:0]   be;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] wrdata;
  logic [DATA_W-1:0] rddata;
  logic              ac;

  modport master (output addr, be, read, write, wrdata, input rddata, ac);
  modport slave  (input addr, be, read, write, wrdata, output rddata, ac);
endinterface

// File: rtl/sdram_multi_arbiter_picker.sv
// Combinational grant picker: lowest-index urgent request first, else round-robin after last.
module rr_priority_picker
  import sdram_arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = clog2w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  urgent,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] gnt_idx,
  output logic          any_gnt
);
  logic [N-1:0] urg;
  int           j;

  always_comb begin
    urg     = req & urgent;
    any_gnt = |req;
    gnt_idx = '0;
    j       = 0;
    // Scans run from the far end so the closest hit is the last assignment.
    if (|urg) begin
      for (int i = N - 1; i >= 0; i--)
        if (urg[i]) gnt_idx = IW'(i);
    end else begin
      for (int k = N; k >= 1; k--) begin
        j = (int'(last) + k) % N;
        if (req[j]) gnt_idx = IW'(j);
      end
    end
  end
endmodule

// File: rtl/sdram_multi_arbiter.sv
// N-client arbiter for one SDRAM controller port: urgent-first round-robin,
// enable masking, lock-hold bursts and a starvation cap on consecutive acks.
module sdram_multi_arbiter
  import sdram_arb_pkg::*;
#(
  parameter  int N_CLIENTS = 4,
  parameter  int ADDR_W    = DEF_ADDR_W,
  parameter  int DATA_W    = DEF_DATA_W,
  parameter  int MAX_BURST = DEF_MAX_BURST,
  localparam int BE_W      = DATA_W / 8,
  localparam int IW        = clog2w(N_CLIENTS),
  localparam int BW        = clog2w(MAX_BURST + 1)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [N_CLIENTS-1:0]             cli_enable,
  input  logic [N_CLIENTS-1:0]             cli_urgent,
  input  logic [N_CLIENTS-1:0]             cli_read,
  input  logic [N_CLIENTS-1:0]             cli_write,
  input  logic [N_CLIENTS-1:0]             cli_lock,
  input  logic [N_CLIENTS-1:0][ADDR_W-1:0] cli_addr,
  input  logic [N_CLIENTS-1:0][BE_W-1:0]   cli_be,
  input  logic [N_CLIENTS-1:0][DATA_W-1:0] cli_wrdata,
  output logic [N_CLIENTS-1:0][DATA_W-1:0] cli_rddata,
  output logic [N_CLIENTS-1:0]             cli_ac,
  output logic [N_CLIENTS-1:0]             cli_wait,
  sdram_multi_arbiter_if.master            mem,
  output logic [IW-1:0]                    owner_id,
  output logic                             busy
);
  arb_state_e           state, state_d;
  logic [IW-1:0]        owner, last_owner, gnt_idx;
  logic [BW-1:0]        burst_cnt;
  logic                 any_gnt, own_req, release_now;
  logic [N_CLIENTS-1:0] cand, others;

  assign cand = cli_enable & (cli_read | cli_write);

  rr_priority_picker #(.N(N_CLIENTS)) u_pick (
    .req     (cand),
    .urgent  (cli_urgent),
    .last    (last_owner),
    .gnt_idx (gnt_idx),
    .any_gnt (any_gnt)
  );

  always_comb begin
    others        = cand;
    others[owner] = 1'b0;
    own_req       = cli_read[owner] | cli_write[owner];
    release_now   = 1'b0;
    state_d       = state;
    case (state)
      IDLE: if (any_gnt) state_d = OWN;
      OWN: begin
        // Starvation cap ignores lock; the other two exits need the request gone.
        release_now = (!own_req && !cli_lock[owner])
                   || (mem.ac && burst_cnt == BW'(MAX_BURST - 1) && |others)
                   || (!cli_enable[owner] && !own_req);
        if (release_now) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= IW'(N_CLIENTS - 1);
      burst_cnt  <= '0;
    end else begin
      state <= state_d;
      if (state == IDLE && any_gnt) begin
        owner      <= gnt_idx;
        last_owner <= gnt_idx;
        burst_cnt  <= '0;
      end else if (state == OWN && mem.ac && burst_cnt != BW'(MAX_BURST)) begin
        burst_cnt <= burst_cnt + 1'b1;
      end
    end
  end

  assign busy     = (state == OWN);
  assign owner_id = owner;

  always_comb begin
    mem.addr   = '0;
    mem.be     = '0;
    mem.read   = 1'b0;
    mem.write  = 1'b0;
    mem.wrdata = '0;
    if (busy) begin
      mem.addr   = cli_addr[owner];
      mem.be     = cli_be[owner];
      mem.write  = cli_write[owner];
      mem.read   = cli_read[owner] & ~cli_write[owner];
      mem.wrdata = cli_wrdata[owner];
    end
  end

  for (genvar i = 0; i < N_CLIENTS; i++) begin : g_cli
    logic sel;
    assign sel           = busy && (owner == IW'(i));
    assign cli_ac[i]     = sel & mem.ac;
    assign cli_wait[i]   = ~sel;
    assign cli_rddata[i] = sel ? mem.rddata : '0;
  end
endmodule

// File: tb/tb_sdram_multi_arbiter.sv
// Bench for sdram_multi_arbiter: vector table, directed corner sequences, random traffic vs model.
module tb_sdram_multi_arbiter;
  localparam int N = 4, AW = 22, DW = 128, BEW = 16, MB = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [N-1:0]          en, urg, rd, wr, lock;
  logic [N-1:0][AW-1:0]  addr;
  logic [N-1:0][BEW-1:0] be;
  logic [N-1:0][DW-1:0]  wd, rdd;
  logic [N-1:0]          cli_ac, cli_wait;
  logic [1:0]            owner_id;
  logic                  busy;
  logic                  ac;
  logic [DW-1:0]         mrd;

  sdram_multi_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m();
  assign m.ac     = ac;
  assign m.rddata = mrd;

  sdram_multi_arbiter #(.N_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset),
    .cli_enable(en), .cli_urgent(urg), .cli_read(rd), .cli_write(wr), .cli_lock(lock),
    .cli_addr(addr), .cli_be(be), .cli_wrdata(wd), .cli_rddata(rdd),
    .cli_ac(cli_ac), .cli_wait(cli_wait), .mem(m), .owner_id(owner_id), .busy(busy)
  );

  int errors = 0, checks = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: who owns the port, who owned it last, acks taken in this tenure.
  bit m_own;
  int m_owner, m_last, m_cnt;
  logic                  e_rd, e_wr;
  logic [AW-1:0]         e_addr;
  logic [BEW-1:0]        e_be;
  logic [DW-1:0]         e_wd;
  logic [N-1:0]          e_ac, e_wait;
  logic [N-1:0][DW-1:0]  e_rdd;

  bit           auto_ac, prev_busy;
  int           ac_pct, ac0_cnt, strb_cnt;
  logic [N-1:0] hold;
  int           gq[$];

  function automatic int pick(input logic [N-1:0] c, input logic [N-1:0] u, input int last);
    for (int i = 0; i < N; i++) if (c[i] && u[i]) return i;
    for (int k = 1; k <= N; k++) if (c[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic compute_exp();
    e_rd = 0; e_wr = 0; e_addr = '0; e_be = '0; e_wd = '0;
    e_ac = '0; e_wait = '1; e_rdd = '0;
    if (m_own) begin
      e_wr = wr[m_owner];
      e_rd = rd[m_owner] & ~wr[m_owner];
      e_addr = addr[m_owner]; e_be = be[m_owner]; e_wd = wd[m_owner];
      e_ac[m_owner] = ac; e_wait[m_owner] = 1'b0; e_rdd[m_owner] = mrd;
    end
  endtask

  task automatic model_update();
    logic [N-1:0] c;
    int w;
    logic req_o;
    c = en & (rd | wr);
    if (reset) begin
      m_own = 0; m_owner = 0; m_last = N - 1; m_cnt = 0;
    end else if (!m_own) begin
      w = pick(c, urg, m_last);
      if (w >= 0) begin m_own = 1; m_owner = w; m_last = w; m_cnt = 0; end
    end else begin
      req_o = rd[m_owner] | wr[m_owner];
      c[m_owner] = 1'b0;
      if ((!req_o && !lock[m_owner]) || (ac && m_cnt == MB - 1 && |c) || (!en[m_owner] && !req_o))
        m_own = 0;
      if (ac && m_cnt < MB) m_cnt++;
    end
  endtask

  // One clock: drive responder, check every output against the model, advance.
  task automatic step();
    logic strobe;
    strobe = m_own && (rd[m_owner] | wr[m_owner]);
    if (auto_ac) ac = strobe && ($urandom_range(0, 99) < ac_pct);
    mrd = {$urandom, $urandom, $urandom, $urandom};
    compute_exp();
    #1;
    chk("busy", busy, m_own);
    if (m_own) chk("owner_id", owner_id, m_owner);
    chk("mem_read", m.read, e_rd);
    chk("mem_write", m.write, e_wr);
    chk("mem_addr", m.addr, e_addr);
    chk("mem_be", m.be, e_be);
    chk("mem_wrdata", m.wrdata, e_wd);
    chk("cli_ac", cli_ac, e_ac);
    chk("cli_wait", cli_wait, e_wait);
    chk("cli_rddata", rdd, e_rdd);
    if (busy && !prev_busy) gq.push_back(int'(owner_id));
    prev_busy = busy;
    ac0_cnt += int'(cli_ac[0]);
    strb_cnt += int'(m.read | m.write);
    model_update();
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < N; i++)
      if (e_ac[i] && !hold[i]) begin rd[i] = 0; wr[i] = 0; urg[i] = 0; end
  endtask

  task automatic clr();
    en = '0; urg = '0; rd = '0; wr = '0; lock = '0; hold = '0;
    addr = '0; be = '0; wd = '0; ac = 0; auto_ac = 0; ac_pct = 0;
  endtask

  task automatic rst();
    clr();
    reset = 1;
    step();
    reset = 0;
  endtask

  typedef struct {
    logic [N-1:0] en, urg, rd, wr;
    bit busy; int owner; bit erd, ewr;
  } vec_t;
  vec_t tbl[9];

  initial begin
    tbl[0] = '{4'hF, 4'h0, 4'b0101, 4'h0, 1'b1, 0, 1'b1, 1'b0};
    tbl[1] = '{4'hF, 4'b0100, 4'b0101, 4'h0, 1'b1, 2, 1'b1, 1'b0};
    tbl[2] = '{4'b1011, 4'h0, 4'b0100, 4'h0, 1'b0, 0, 1'b0, 1'b0};
    tbl[3] = '{4'hF, 4'h0, 4'b0110, 4'h0, 1'b1, 1, 1'b1, 1'b0};
    tbl[4] = '{4'hF, 4'h0, 4'b1000, 4'b1000, 1'b1, 3, 1'b0, 1'b1};
    tbl[5] = '{4'hF, 4'b1010, 4'b1010, 4'h0, 1'b1, 1, 1'b1, 1'b0};
    tbl[6] = '{4'hF, 4'b0001, 4'b0010, 4'h0, 1'b1, 1, 1'b1, 1'b0};
    tbl[7] = '{4'h0, 4'h0, 4'hF, 4'h0, 1'b0, 0, 1'b0, 1'b0};
    tbl[8] = '{4'b0111, 4'b1000, 4'b1000, 4'b0100, 1'b1, 2, 1'b0, 1'b1};

    clr(); mrd = '0; reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    m_own = 0; m_owner = 0; m_last = N - 1; m_cnt = 0; prev_busy = 0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_owner_id", owner_id, 0);
    chk("rst_cli_wait", cli_wait, 4'hF);
    chk("rst_strobes", {m.read, m.write}, 2'b00);
    chk("rst_mem_addr", m.addr, 0);
    chk("rst_cli_ac", cli_ac, 0);
    reset = 0;
    step();

    foreach (tbl[k]) begin
      rst();
      en = tbl[k].en; urg = tbl[k].urg; rd = tbl[k].rd; wr = tbl[k].wr;
      step();
      #1;
      chk($sformatf("tbl%0d_busy", k), busy, tbl[k].busy);
      if (tbl[k].busy) chk($sformatf("tbl%0d_owner", k), owner_id, tbl[k].owner);
      chk($sformatf("tbl%0d_read", k), m.read, tbl[k].erd);
      chk($sformatf("tbl%0d_write", k), m.write, tbl[k].ewr);
    end

    // Two plain readers: 0 first, one dead IDLE cycle, then 2.
    rst();
    en = '1; rd = 4'b0101; addr[0] = 22'h111; addr[2] = 22'h222;
    step();
    #1 chk("A_first", {busy, owner_id, m.read}, {1'b1, 2'd0, 1'b1});
    ac = 1; step(); ac = 0;
    step();
    #1 chk("A_dead", busy, 0);
    step();
    #1 chk("A_second", {busy, owner_id, m.read, m.addr}, {1'b1, 2'd2, 1'b1, 22'h222});
    ac = 1; step(); ac = 0; step();

    // Locked streamer hits the ack cap while client 3 waits.
    rst();
    en = '1; rd = 4'b1010; lock[1] = 1; hold[1] = 1;
    step();
    #1 chk("B_owner1", {busy, owner_id}, {1'b1, 2'd1});
    ac = 1; repeat (MB) step(); ac = 0;
    #1 chk("B_release", busy, 0);
    step();
    #1 chk("B_next", {busy, owner_id, m.read}, {1'b1, 2'd3, 1'b1});
    ac = 1; step(); ac = 0;

    // Urgent first, then round-robin from it.
    rst();
    gq.delete();
    en = '1; rd = 4'b0111; urg = 4'b0100; auto_ac = 1; ac_pct = 100;
    repeat (12) step();
    chk("C_order_n", gq.size(), 3);
    if (gq.size() == 3) begin
      chk("C_order0", gq[0], 2);
      chk("C_order1", gq[1], 0);
      chk("C_order2", gq[2], 1);
    end

    // Owner disabled while its write is outstanding.
    rst();
    ac0_cnt = 0;
    en = '1; wr[0] = 1; addr[0] = 22'h3FFFFF; be[0] = 16'h00FF;
    wd[0] = {$urandom, $urandom, $urandom, $urandom};
    step();
    #1 chk("D_write", {m.write, m.addr, m.be}, {1'b1, 22'h3FFFFF, 16'h00FF});
    en[0] = 0;
    step(); step();
    #1 chk("D_still_owned", {busy, m.write}, 2'b11);
    ac = 1; step(); ac = 0;
    step(); step();
    #1 chk("D_busy", busy, 0);
    chk("D_ac_pulses", ac0_cnt, 1);

    // Reset during a read; a late ack must not be routed.
    rst();
    en = '1; rd[1] = 1;
    step();
    #1 chk("E_read", {busy, owner_id, m.read}, {1'b1, 2'd1, 1'b1});
    reset = 1; step(); reset = 0;
    #1;
    chk("E_rd_low", m.read, 0);
    chk("E_busy", busy, 0);
    chk("E_wait", cli_wait, 4'hF);
    ac = 1;
    #1 chk("E_late_ac", cli_ac, 0);
    step(); ac = 0;

    // Disabled requester alone never gets the port.
    rst();
    strb_cnt = 0;
    en = 4'b1011; rd[2] = 1;
    repeat (6) step();
    chk("F_idle", busy, 0);
    chk("F_strobes", strb_cnt, 0);

    // Random traffic against the model.
    rst();
    en = '1; auto_ac = 1; ac_pct = 60;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      reset = ($urandom_range(0, 499) == 0);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 15) == 0) en[i] = ~en[i];
        if ($urandom_range(0, 7) == 0) lock[i] = 1'($urandom_range(0, 1));
        if (!(rd[i] | wr[i]) && $urandom_range(0, 3) == 0) begin
          case ($urandom_range(0, 4))
            0, 1:    rd[i] = 1;
            2, 3:    wr[i] = 1;
            default: begin rd[i] = 1; wr[i] = 1; end
          endcase
          addr[i] = AW'($urandom);
          be[i]   = BEW'($urandom);
          wd[i]   = {$urandom, $urandom, $urandom, $urandom};
          urg[i]  = ($urandom_range(0, 5) == 0);
        end
      end
      step();
    end
    reset = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
